configs_loader: RTL and testbench
=================================

// Module: configs_loader
// PURPOSE
//  Sequencer directly upstream of the configuration latch bank. Accepts config words over a
//  valid/ready stream and drives the bank's shared data bus plus a one-hot latch-enable vector.
//  Data is stable before, during and after each enable pulse (setup/strobe/hold), so the
//  transparent latches capture cleanly. Flags completion or a load error to the tile controller.
// PARAMETERS
//  WORD_W         32  width of config word / latch data bus
//  NUM_WORDS      27  number of latch groups (enable vector width); total bits = WORD_W*NUM_WORDS
//  STROBE_CYCLES  1   cycles each enable is held high (>=1)
// PORTS
//  clk             in   1                  clock
//  reset           in   1                  asynchronous reset, active-high
//  io_start        in   1                  pulse: begin load at word 0 (ignored while io_busy)
//  io_in_valid     in   1                  config word valid
//  io_in_ready     out  1                  loader can take a word
//  io_in_bits      in   WORD_W             config word
//  io_in_parity    in   1                  even-parity bit for io_in_bits (used only with CFG_PARITY_EN)
//  io_d_in         out  WORD_W             data bus to latch bank
//  io_configs_en   out  NUM_WORDS          one-hot latch enables, registered, glitch-free
//  io_busy         out  1                  load in progress
//  io_done         out  1                  all NUM_WORDS written; held until next io_start
//  io_error        out  1                  parity abort; held until next io_start (0 w/o macro)
//  io_word_idx     out  clog2(NUM_WORDS)   index of current/next word
// BEHAVIOUR
//  Reset (async): state IDLE; io_d_in=0, io_configs_en=0, io_in_ready=0, io_busy=0, io_done=0,
//   io_error=0, io_word_idx=0. Latch contents downstream are not touched.
//  All outputs are flop outputs; io_configs_en has no combinational path from any input.
//  FSM: IDLE, WAIT_WORD, SETUP, STROBE, HOLD, DONE.
//   IDLE/DONE: io_start -> WAIT_WORD; idx=0, io_done=0, io_error=0, io_busy=1.
//   WAIT_WORD: io_in_ready=1 (only state with ready=1). valid&&ready -> capture word to io_d_in, ->SETUP.
//   SETUP: 1 cycle, en=0, io_d_in stable. -> STROBE.
//   STROBE: STROBE_CYCLES cycles, io_configs_en[idx]=1, all other bits 0. -> HOLD.
//   HOLD: 1 cycle, en=0, io_d_in unchanged. idx==NUM_WORDS-1 -> DONE (io_done=1, io_busy=0);
//    else idx+=1 -> WAIT_WORD.
//  Throughput: 3+STROBE_CYCLES cycles/word min (4 at default; full load 108 cycles min).
//  io_d_in changes only on the WAIT_WORD handshake edge; never while any enable is high.
//  io_start while io_busy: ignored. io_start same cycle as stream valid in IDLE: word not taken
//   (ready=0 in IDLE); first word accepted earliest next cycle.
//  Stream stall (valid low) in WAIT_WORD: wait indefinitely, en stays 0.
//  Reset mid-load (incl. during STROBE): enables drop asynchronously; restart requires io_start.
//  idx never exceeds NUM_WORDS-1; no wrap.
// CONFIGURATION
//  CFG_PARITY_EN defined: on handshake, if ^{io_in_bits,io_in_parity}!=0 the word is not
//   captured/strobed; -> IDLE with io_error=1, io_busy=0, io_d_in and idx held at failing value.
//  Undefined: io_in_parity ignored, io_error tied 0, no parity logic.
// STRUCTURE
//  configs_pkg: WORD_W/NUM_WORDS defaults, IDX_W=$clog2(NUM_WORDS), state enum typedef.
//  Sub-module configs_en_decoder: registered idx->one-hot decode gated by strobe flag.
// TESTING
//  1 Full load, valid always 1, words 0x1000_0000+i: en[i] pulses once 1 cycle, in order;
//    io_d_in==word i throughout SETUP..HOLD; io_done at cycle 108 after first ready.
//  2 Valid gaps of 5 cycles between words: en stays 0 in gaps; io_d_in never changes with en!=0.
//  3 Reset asserted during STROBE of word 13: en==0 same cycle, all outputs at reset values;
//    new io_start reloads from idx 0.
//  4 io_start pulsed at word 7 mid-load: ignored; load completes, io_done=1 exactly once.
//  5 (CFG_PARITY_EN) bad parity on word 4 (0xDEAD_BEEF, parity 1): no en[4] pulse, io_error=1,
//    io_busy=0, idx=4; next io_start clears error and loads 27 words cleanly.
//  6 STROBE_CYCLES=3, NUM_WORDS=4: each en high exactly 3 cycles; 6 cycles/word.

Source files
------------

// File: rtl/configs_pkg.sv
// Shared defaults, state encoding and width helper for the configuration latch loader.
package configs_pkg;

  localparam int unsigned WORD_W_DEF        = 32;
  localparam int unsigned NUM_WORDS_DEF     = 27;
  localparam int unsigned STROBE_CYCLES_DEF = 1;
  localparam int unsigned IDX_W             = $clog2(NUM_WORDS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/configs_en_decoder.sv
// Registered index-to-one-hot decode of the latch enables, gated by the strobe flag.
module configs_en_decoder
#(
  parameter int unsigned NUM_WORDS = 27,
  parameter int unsigned IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic [IDX_W-1:0]     idx,
  output logic [NUM_WORDS-1:0] en
);

  // Flop output only, so the latch enables cannot glitch and drop with reset at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= '0;
    end else begin
      en <= strobe ? (NUM_WORDS'(1'b1) << idx) : '0;
    end
  end

endmodule

// File: rtl/configs_loader.sv
// Streams config words onto the latch-bank data bus with setup/strobe/hold sequencing.
// Optional CFG_PARITY_EN: even-parity check on each accepted word, aborting the load on error.
module configs_loader
  import configs_pkg::*;
#(
  parameter  int unsigned WORD_W        = WORD_W_DEF,
  parameter  int unsigned NUM_WORDS     = NUM_WORDS_DEF,
  parameter  int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
  localparam int unsigned IW            = idx_width(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  input  logic                 io_in_parity,
  output logic [WORD_W-1:0]    io_d_in,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_error,
  output logic [IW-1:0]        io_word_idx
);

  localparam int unsigned     CW       = idx_width(STROBE_CYCLES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(STROBE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                strobe_d;
  logic                parity_bad;

`ifdef CFG_PARITY_EN
  assign parity_bad = ^{io_in_bits, io_in_parity};
`else
  logic unused_parity;
  assign unused_parity = io_in_parity;
  assign parity_bad    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; ready/strobe are precomputed so they leave flops.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    strobe_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (io_start) begin
          state_d = ST_WAIT_WORD;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT_WORD: begin
        if (io_in_valid) begin
          if (parity_bad) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            data_d  = io_in_bits;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_WAIT_WORD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_WAIT_WORD);
    strobe_d = (state_d == ST_STROBE);
  end

  configs_en_decoder #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IW)
  ) u_en_decoder (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe_d),
    .idx    (idx_d),
    .en     (io_configs_en)
  );

  assign io_in_ready = ready_q;
  assign io_d_in     = data_q;
  assign io_busy     = busy_q;
  assign io_done     = done_q;
  assign io_error    = err_q;
  assign io_word_idx = idx_q;

endmodule

// File: tb/tb_configs_loader.sv
// Scoreboard bench for configs_loader: random words/gaps against a load-level reference model.
`timescale 1ns/1ps
module tb_configs_loader;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 27;
  localparam int unsigned S  = 1;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned N6 = 4;
  localparam int unsigned S6 = 3;
  localparam int K_STROBE = 0;
  localparam int K_DONE   = 1;
  localparam int K_ERROR  = 2;

  logic clk = 1'b0;
  logic reset;
  logic io_start, io_in_valid, io_in_ready, io_in_parity;
  logic [W-1:0] io_in_bits, io_d_in;
  logic [N-1:0] io_configs_en;
  logic io_busy, io_done, io_error;
  logic [IW-1:0] io_word_idx;

  logic s6_start, s6_valid, s6_ready, s6_parity, s6_busy, s6_done, s6_error;
  logic [W-1:0] s6_bits, s6_d;
  logic [N6-1:0] s6_en;
  logic [1:0] s6_idx;

  always #5 clk = ~clk;

  configs_loader u_dut (
    .clk(clk), .reset(reset), .io_start(io_start), .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready), .io_in_bits(io_in_bits), .io_in_parity(io_in_parity),
    .io_d_in(io_d_in), .io_configs_en(io_configs_en), .io_busy(io_busy),
    .io_done(io_done), .io_error(io_error), .io_word_idx(io_word_idx)
  );

  configs_loader #(.WORD_W(W), .NUM_WORDS(N6), .STROBE_CYCLES(S6)) u_dut6 (
    .clk(clk), .reset(reset), .io_start(s6_start), .io_in_valid(s6_valid),
    .io_in_ready(s6_ready), .io_in_bits(s6_bits), .io_in_parity(s6_parity),
    .io_d_in(s6_d), .io_configs_en(s6_en), .io_busy(s6_busy),
    .io_done(s6_done), .io_error(s6_error), .io_word_idx(s6_idx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected event per accepted word, plus a done/error event.
  typedef struct { int kind; int idx; logic [W-1:0] word; } exp_t;
  exp_t exp_q[$];
  int   model_idx  = 0;
  bit   model_busy = 1'b0;

  function automatic bit parity_ok(input logic [W-1:0] w, input logic p);
`ifdef CFG_PARITY_EN
    return ((^w) == p);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic mk_par(input logic [W-1:0] w);
`ifdef CFG_PARITY_EN
    return ^w;
`else
    return 1'($urandom);
`endif
  endfunction

  task automatic model_accept(input logic [W-1:0] w, input logic p);
    if (!parity_ok(w, p)) begin
      exp_q.push_back('{K_ERROR, model_idx, w});
      model_busy = 1'b0;
    end else begin
      exp_q.push_back('{K_STROBE, model_idx, w});
      if (model_idx == int'(N) - 1) begin
        exp_q.push_back('{K_DONE, model_idx, w});
        model_busy = 1'b0;
      end else begin
        model_idx++;
      end
    end
  endtask

  task automatic pulse_start();
    io_start = 1'b1;
    if (!model_busy) begin
      model_idx  = 0;
      model_busy = 1'b1;
    end
    @(negedge clk);
    io_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic p, input int gap);
    int t;
    repeat (gap) begin
      io_in_valid = 1'b0;
      @(negedge clk);
    end
    io_in_bits   = w;
    io_in_parity = p;
    io_in_valid  = 1'b1;
    t = 0;
    while (!io_in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!io_in_ready) check("ready_timeout", io_in_ready, 1);
    else begin
      model_accept(w, p);
      @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!io_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", io_done, 1);
  endtask

  task automatic full_load(input int max_gap);
    logic [W-1:0] w;
    pulse_start();
    for (int i = 0; i < int'(N); i++) begin
      w = $urandom;
      send_word(w, mk_par(w), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    io_in_valid = 1'b0;
    wait_done();
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts a strobe, finishes or errors.
  logic [N-1:0] prev_en;
  logic [W-1:0] prev_d, strobe_word;
  logic         prev_done, prev_err;
  int           en_len;
  exp_t         e;
  bit           have;

  always @(negedge clk) begin
    if (reset) begin
      prev_en   = '0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
      en_len    = 0;
      prev_d    = io_d_in;
    end else begin
      if (io_configs_en != '0 && prev_en == '0) begin
        have = (exp_q.size() > 0) && (exp_q[0].kind == K_STROBE);
        check("strobe_expected", have, 1);
        if (have) begin
          e = exp_q.pop_front();
          check("en_onehot", io_configs_en, N'(1) << e.idx);
          check("d_at_strobe", io_d_in, e.word);
          check("d_setup", prev_d, e.word);
          strobe_word = e.word;
        end
        en_len = 1;
      end else if (io_configs_en != '0) begin
        en_len++;
        check("en_stable", io_configs_en, prev_en);
        check("d_during_strobe", io_d_in, strobe_word);
      end else if (prev_en != '0) begin
        check("strobe_len", en_len, S);
        check("d_hold", io_d_in, strobe_word);
      end
      if (io_done && !prev_done) begin
        have = (exp_q.size() > 0) && (exp_q[0].kind == K_DONE);
        check("done_expected", have, 1);
        if (have) void'(exp_q.pop_front());
        check("busy_at_done", io_busy, 0);
        check("idx_at_done", io_word_idx, N - 1);
      end
      if (io_error && !prev_err) begin
        have = (exp_q.size() > 0) && (exp_q[0].kind == K_ERROR);
        check("error_expected", have, 1);
        if (have) begin
          e = exp_q.pop_front();
          check("err_idx", io_word_idx, e.idx);
        end
        check("err_busy", io_busy, 0);
      end
      prev_en   = io_configs_en;
      prev_d    = io_d_in;
      prev_done = io_done;
      prev_err  = io_error;
    end
  end

  // Small-instance observer: per-index high time and rise order.
  int len6 [N6];
  int rise6[N6];
  int ord6 [$];
  logic [N6-1:0] prev6 = '0;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N6); i++) begin
        if (s6_en[i]) len6[i]++;
        if (s6_en[i] && !prev6[i]) begin
          rise6[i]++;
          ord6.push_back(i);
        end
      end
      prev6 = s6_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0, t;
    logic [W-1:0] w, last_good;
    io_start = 0; io_in_valid = 0; io_in_bits = '0; io_in_parity = 0;
    s6_start = 0; s6_valid = 0; s6_bits = '0; s6_parity = 0;
    for (int i = 0; i < int'(N6); i++) begin len6[i] = 0; rise6[i] = 0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_d_in", io_d_in, 0);
    check("rst_en", io_configs_en, 0);
    check("rst_ready", io_in_ready, 0);
    check("rst_flags", {io_busy, io_done, io_error}, 0);
    check("rst_idx", io_word_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full load with valid held high; first word offered together with start.
    io_in_bits = 32'h1000_0000; io_in_parity = mk_par(32'h1000_0000); io_in_valid = 1'b1;
    c0 = cyc;
    pulse_start();
    check("start_busy", io_busy, 1);
    check("start_idx", io_word_idx, 0);
    check("start_ready", io_in_ready, 1);
    for (int i = 0; i < int'(N); i++) begin
      w = 32'h1000_0000 + W'(i);
      send_word(w, mk_par(w), 0);
    end
    io_in_valid = 1'b0;
    wait_done();
    check("done_latency", cyc - c0, 1 + N * (3 + S));

    // Five-cycle valid gaps between words.
    pulse_start();
    check("restart_done_clr", io_done, 0);
    for (int i = 0; i < int'(N); i++) begin
      w = $urandom;
      send_word(w, mk_par(w), 5);
    end
    io_in_valid = 1'b0;
    wait_done();

    // Reset while word 13 is strobing.
    pulse_start();
    for (int i = 0; i <= 13; i++) begin
      w = $urandom;
      send_word(w, mk_par(w), int'($urandom_range(0, 2)));
    end
    io_in_valid = 1'b0;
    t = 0;
    while (!io_configs_en[13] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("en13_seen", io_configs_en[13], 1);
    #1 reset = 1'b1;
    #1;
    check("midrst_en", io_configs_en, 0);
    check("midrst_d_in", io_d_in, 0);
    check("midrst_flags", {io_in_ready, io_busy, io_done, io_error}, 0);
    check("midrst_idx", io_word_idx, 0);
    exp_q.delete();
    model_busy = 1'b0;
    model_idx  = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    io_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("no_restart_ready", io_in_ready, 0);
    check("no_restart_en", io_configs_en, 0);
    io_in_valid = 1'b0;
    full_load(2);

    // Start pulsed mid-load must be ignored.
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      w = $urandom;
      send_word(w, mk_par(w), int'($urandom_range(0, 3)));
    end
    io_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start();
    check("ignored_start_idx", io_word_idx, 7);
    check("ignored_start_busy", io_busy, 1);
    for (int i = 7; i < int'(N); i++) begin
      w = $urandom;
      send_word(w, mk_par(w), int'($urandom_range(0, 3)));
    end
    io_in_valid = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    check("done_held", io_done, 1);

`ifdef CFG_PARITY_EN
    // Bad parity on word 4 aborts the load.
    pulse_start();
    last_good = '0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      last_good = w;
      send_word(w, ^w, 0);
    end
    send_word(32'hDEAD_BEEF, 1'b1, 0);
    io_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("par_error", io_error, 1);
    check("par_busy", io_busy, 0);
    check("par_idx", io_word_idx, 4);
    check("par_d_held", io_d_in, last_good);
    pulse_start();
    check("par_err_clr", io_error, 0);
    for (int i = 0; i < int'(N); i++) begin
      w = $urandom;
      send_word(w, ^w, 0);
    end
    io_in_valid = 1'b0;
    wait_done();
`else
    last_good = '0;
    check("error_tied", io_error, last_good[0]);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    // Four words with a three-cycle strobe on the small instance.
    s6_valid = 1'b1;
    s6_bits  = $urandom;
    c0 = cyc;
    s6_start = 1'b1;
    @(negedge clk);
    s6_start = 1'b0;
    t = 0;
    while (!s6_done && t < 100) begin
      @(negedge clk);
      s6_bits = $urandom;
      t++;
    end
    check("s6_done_seen", s6_done, 1);
    check("s6_latency", cyc - c0, 1 + N6 * (3 + S6));
    check("s6_rises", ord6.size(), N6);
    for (int i = 0; i < int'(N6); i++) begin
      check("s6_en_len", len6[i], S6);
      check("s6_en_once", rise6[i], 1);
      if (i < ord6.size()) check("s6_order", ord6[i], i);
    end
    s6_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
